multiplier_ctrl: RTL

Sequencer for the 8-bit shift-add `multiplier` datapath. It accepts an operand pair through a start/ready/done handshake, converts signed operands to magnitudes, and loads the datapath. It then steps the datapath with `enable`/`Psel` until the multiplier register is exhausted, and returns the sign-corrected 16-bit product. It sits between the system-level requester and one `multiplier` instance.

---
 rtl/multiplier_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/multiplier_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_ctrl
// Purpose  : Sequencer for an 8-bit shift-add multiplier datapath. Accepts an
//            operand pair on a start/ready handshake, converts signed operands
//            to magnitudes, loads and steps the datapath until the multiplier
//            register is exhausted, then returns the sign-corrected product.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start, a, b         - request and operands (sampled when ready)
//            ready, done, result - handshake status and 16-bit product
//            dp_mp, dp_mc        - registered operand magnitudes to datapath
//            dp_load, dp_enable,
//            dp_psel             - datapath control strobes
//            dp_b0, dp_zero_flag,
//            dp_product          - datapath status and accumulator
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_ctrl #(
  parameter int SIGNED   = 1,
  parameter int MAX_ITER = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        ready,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  dp_mp,
  output logic [7:0]  dp_mc,
  output logic        dp_load,
  output logic        dp_enable,
  output logic        dp_psel,
  input  logic        dp_b0,
  input  logic        dp_zero_flag,
  input  logic [15:0] dp_product
);

  localparam int CNT_W = $clog2(MAX_ITER + 1);
  localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;
  logic [15:0]       result_q;
  logic [7:0]        dp_mp_q;
  logic [7:0]        dp_mc_q;

  logic [7:0]        mag_a_d;
  logic [7:0]        mag_b_d;
  logic              neg_d;
  logic [15:0]       result_d;
  logic              run_step;

  // |x| as 8-bit unsigned; -128 wraps to 0x80, which is the correct magnitude.
  function automatic logic [7:0] magnitude(input logic [7:0] x);
    if ((SIGNED != 0) && x[7]) begin
      return ~x + 8'd1;
    end
    return x;
  endfunction

  always_comb begin
    mag_a_d  = magnitude(a);
    mag_b_d  = magnitude(b);
    neg_d    = (SIGNED != 0) ? (a[7] ^ b[7]) : 1'b0;
    // Two's-complement negate of zero is zero, so no special case is needed.
    result_d = neg_q ? (~dp_product + 16'd1) : dp_product;
  end

  // A RUN cycle steps the datapath unless the multiplier register is empty
  // or the iteration cap has been reached.
  assign run_step = (state_q == S_RUN) && !dp_zero_flag && (cnt_q != C_MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= 16'd0;
      dp_mp_q  <= 8'd0;
      dp_mc_q  <= 8'd0;
    end else begin
      case (state_q)
        // DONE accepts a new request exactly like IDLE so that back-to-back
        // operations need no idle cycle.
        S_IDLE, S_DONE: begin
          if (start) begin
            dp_mp_q <= mag_a_d;
            dp_mc_q <= mag_b_d;
            neg_q   <= neg_d;
            cnt_q   <= '0;
            state_q <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (run_step) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= result_d;
          state_q  <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status and load strobe are decoded straight from the state register.
  assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign dp_load   = (state_q == S_LOAD);
  assign dp_enable = run_step;
  assign dp_psel   = run_step & dp_b0;
  assign result    = result_q;
  assign dp_mp     = dp_mp_q;
  assign dp_mc     = dp_mc_q;

endmodule
`default_nettype wire
